// File: rtl/ofm_pack_writer_if.sv
// Bus bundle for the OFM pack writer: the 16-lane PE result stream coming in
// and the 32-bit BRAM write port going out.
interface ofm_pack_writer_if #(
    parameter int NUM_PE = 16,
    parameter int ADDR_W = 20
);
    logic [8*NUM_PE-1:0] ofm_bytes;
    logic [NUM_PE-1:0]   valid;
    logic                mem_ready;
    logic                mem_wr_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_data;

    // Environment side: drives PE results and BRAM ready, observes writes
    modport master (
        output ofm_bytes, valid, mem_ready,
        input  mem_wr_en, mem_addr, mem_data
    );

    // Writer side
    modport slave (
        input  ofm_bytes, valid, mem_ready,
        output mem_wr_en, mem_addr, mem_data
    );
endinterface

// File: rtl/ofm_pack_writer.sv
// OFM pack writer: captures complete 16-channel groups from the PE array,
// queues them in a small FIFO and writes each as four big-endian-packed
// 32-bit words to the OFM BRAM at its NHWC word address.
module ofm_pack_writer #(
    parameter int NUM_PE     = 16,
    parameter int ADDR_W     = 20,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        OFM_W,
    input  logic [7:0]        OFM_C,
    ofm_pack_writer_if.slave  bus,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              partial_err
);
    localparam int WORDS = NUM_PE / 4;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_ST} state_t;

    state_t state_reg, state_next;

    // Layer configuration and position counters
    logic [7:0]  cfg_w_reg, cfg_c_reg;
    logic [15:0] pix_reg;
    logic [3:0]  grp_reg;
    logic        overflow_reg, partial_err_reg;

    // Group FIFO: payload plus precomputed base word address
    logic [8*NUM_PE-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]    count_reg;

    // Output word register
    logic              wr_en_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       data_reg;
    logic [IDX_W-1:0]  idx_reg;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Position bookkeeping
    logic [15:0] pix_total;
    logic        last_pix, last_grp;
    logic [23:0] byte_addr;
    logic [ADDR_W-1:0] word_addr;

    assign pix_total = {8'd0, cfg_w_reg} * {8'd0, cfg_w_reg};
    assign last_pix  = (pix_reg == pix_total - 16'd1);
    assign last_grp  = (grp_reg == cfg_c_reg[7:4] - 4'd1);
    // Products kept 24 bits wide so large layers do not wrap before truncation
    assign byte_addr = {8'd0, pix_reg} * {16'd0, cfg_c_reg} + {16'd0, grp_reg, 4'd0};
    assign word_addr = ADDR_W'(byte_addr >> 2);

    // Capture decode
    logic in_run, grp_full, grp_none, capture, push, pop, drop, bad, fifo_full, accept;
    logic last_capture, drain_complete;

    assign accept       = wr_en_reg && bus.mem_ready;
    assign pop          = accept && (idx_reg == IDX_W'(WORDS - 1));
    // A pop on the same edge frees the slot, so the FIFO is not full then
    assign fifo_full    = (count_reg == CNT_W'(FIFO_DEPTH)) && !pop;
    assign in_run       = (state_reg == RUN);
    assign grp_full     = (bus.valid == '1);
    assign grp_none     = (bus.valid == '0);
    assign capture      = in_run && grp_full;
    assign push         = capture && !fifo_full;
    assign drop         = capture && fifo_full;
    assign bad          = in_run && !grp_full && !grp_none;
    assign last_capture = capture && last_pix && last_grp;
    assign drain_complete = (pop && count_reg == CNT_W'(1)) ||
                            (count_reg == '0 && !wr_en_reg);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_capture) state_next = DRAIN;
            DRAIN:   if (drain_complete) state_next = DONE_ST;
            DONE_ST: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg == RUN) || (state_reg == DRAIN);
    assign done = (state_reg == DONE_ST);

    // Config latch, position counters and sticky error flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            cfg_w_reg       <= '0;
            cfg_c_reg       <= '0;
            pix_reg         <= '0;
            grp_reg         <= '0;
            overflow_reg    <= 1'b0;
            partial_err_reg <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            cfg_w_reg       <= OFM_W;
            cfg_c_reg       <= OFM_C;
            pix_reg         <= '0;
            grp_reg         <= '0;
            overflow_reg    <= 1'b0;
            partial_err_reg <= 1'b0;
        end else begin
            if (capture) begin
                if (last_pix) begin
                    pix_reg <= '0;
                    grp_reg <= grp_reg + 4'd1;
                end else begin
                    pix_reg <= pix_reg + 16'd1;
                end
            end
            if (drop) overflow_reg    <= 1'b1;
            if (bad)  partial_err_reg <= 1'b1;
        end
    end

    assign overflow    = overflow_reg;
    assign partial_err = partial_err_reg;

    // FIFO storage (no reset needed, occupancy tracked separately)
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_reg] <= bus.ofm_bytes;
            fifo_addr[wr_ptr_reg] <= word_addr;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Choose which FIFO entry and word feed the output register next
    logic             load_valid;
    logic [PTR_W-1:0] sel_ptr;
    logic [IDX_W-1:0] load_idx;

    always_comb begin
        load_valid = 1'b0;
        sel_ptr    = rd_ptr_reg;
        load_idx   = '0;
        if (accept && !pop) begin
            load_valid = 1'b1;
            load_idx   = idx_reg + 1'b1;
        end else if (pop) begin
            // Head retires; the next entry (if any) starts at word 0
            load_valid = (count_reg > CNT_W'(1));
            sel_ptr    = ptr_inc(rd_ptr_reg);
        end else if (!wr_en_reg && count_reg != '0) begin
            load_valid = 1'b1;
        end
    end

    // Byte-to-word packing: lowest channel of each word lands in [31:24]
    logic [8*NUM_PE-1:0] sel_bytes;
    logic [31:0]         sel_words [WORDS];

    assign sel_bytes = fifo_data[sel_ptr];

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_pack
        assign sel_words[gi] = {sel_bytes[32*gi      +: 8], sel_bytes[32*gi + 8  +: 8],
                                sel_bytes[32*gi + 16 +: 8], sel_bytes[32*gi + 24 +: 8]};
    end

    // Output word register, held stable while the BRAM stalls
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_en_reg <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
            idx_reg   <= '0;
        end else if (!wr_en_reg || accept) begin
            wr_en_reg <= load_valid;
            if (load_valid) begin
                addr_reg <= fifo_addr[sel_ptr] + ADDR_W'(load_idx);
                data_reg <= sel_words[load_idx];
                idx_reg  <= load_idx;
            end
        end
    end

    assign bus.mem_wr_en = wr_en_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_data  = data_reg;

endmodule
